// File: rtl/alu_pipe_flags.sv
// alu_pipe_flags: handshaked EX-stage ALU with shift-add multiply and an NZCV flag register
module alu_pipe_flags #(
   parameter int WIDTH = 64,
   parameter int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       cntrl,
   input  logic             set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out,
   output logic [3:0]       flags
);
   typedef enum logic {IDLE, MUL} state_t;
   state_t state_q, state_d;
   logic [SHW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, res_q, res_d;
   logic n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d, vld_q, vld_d, sf_q, sf_d;
   logic [3:0] flags_q, flags_d;
   logic acc, hs, sub, is_mul, arith, add_c, add_v;
   logic [WIDTH-1:0] b_op, add_s, alu, prod_nx;
   assign in_ready = state_q == IDLE && (!vld_q || out_ready);
   assign acc = in_valid && in_ready;
   assign hs = vld_q && out_ready;
   assign sub = cntrl == 3'b011;
   assign is_mul = cntrl == 3'b111;
   assign arith = cntrl[2:1] == 2'b01;
   assign b_op = sub ? ~B : B;
   assign {add_c, add_s} = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
   // carry into the MSB recovered from the sum bit, xor'd with carry out
   assign add_v = add_s[WIDTH-1] ^ A[WIDTH-1] ^ b_op[WIDTH-1] ^ add_c;
   assign alu = cntrl == 3'b000 ? B :
                cntrl == 3'b001 ? A << B[SHW-1:0] :
                arith           ? add_s :
                cntrl == 3'b100 ? A & B :
                cntrl == 3'b101 ? A | B : A ^ B;
   assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      mcand_d = mcand_q;
      mplier_d = mplier_q;
      prod_d = prod_q;
      res_d = res_q;
      n_d = n_q;
      z_d = z_q;
      c_d = c_q;
      v_d = v_q;
      vld_d = vld_q;
      sf_d = sf_q;
      if (acc) begin
         state_d = is_mul ? MUL : IDLE;
         vld_d = !is_mul;
         sf_d = set_flags;
         cnt_d = '0;
         mcand_d = A;
         mplier_d = B;
         prod_d = '0;
         if (!is_mul) begin
            res_d = alu;
            n_d = alu[WIDTH-1];
            z_d = alu == '0;
            c_d = arith && add_c;
            v_d = arith && add_v;
         end
      end else if (state_q == MUL) begin
         cnt_d = cnt_q + 1'b1;
         mcand_d = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         prod_d = prod_nx;
         if (cnt_q == SHW'(WIDTH - 1)) begin
            state_d = IDLE;
            vld_d = 1'b1;
            res_d = prod_nx;
            n_d = prod_nx[WIDTH-1];
            z_d = prod_nx == '0;
            c_d = 1'b0;
            v_d = 1'b0;
         end
      end else if (hs) begin
         vld_d = 1'b0;
      end
      flags_d = hs && sf_q ? {n_q, z_q, c_q, v_q} : flags_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
         mcand_q <= '0;
         mplier_q <= '0;
         prod_q <= '0;
         res_q <= '0;
         n_q <= 1'b0;
         z_q <= 1'b0;
         c_q <= 1'b0;
         v_q <= 1'b0;
         vld_q <= 1'b0;
         sf_q <= 1'b0;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         mcand_q <= mcand_d;
         mplier_q <= mplier_d;
         prod_q <= prod_d;
         res_q <= res_d;
         n_q <= n_d;
         z_q <= z_d;
         c_q <= c_d;
         v_q <= v_d;
         vld_q <= vld_d;
         sf_q <= sf_d;
         flags_q <= flags_d;
      end
   end
   assign out_valid = vld_q;
   assign result = res_q;
   assign negative = n_q;
   assign zero = z_q;
   assign carry_out = c_q;
   assign overflow = v_q;
   assign flags = flags_q;
endmodule

// File: tb/tb_alu_pipe_flags.sv
// tb_alu_pipe_flags: random and directed traffic against a transaction-level ALU model
module tb_alu_pipe_flags;
   logic clk = 1'b0, reset = 1'b1;
   logic in_valid = 1'b0, set_flags = 1'b0, out_ready = 1'b0;
   logic [63:0] A = '0, B = '0;
   logic [2:0] cntrl = '0;
   logic in_ready, out_valid, negative, zero, overflow, carry_out;
   logic [63:0] result;
   logic [3:0] flags;
   logic v8 = 1'b0, sf8 = 1'b0, ordy8 = 1'b1;
   logic [7:0] a8 = '0, b8 = '0;
   logic [2:0] op8 = '0;
   logic rdy8, vld8, n8, z8, ov8, c8;
   logic [7:0] res8;
   logic [3:0] flags8;
   int n_chk = 0, n_pass = 0;
   logic m_vld, m_sf, p_sf;
   int m_busy;
   logic [63:0] m_res, p_res;
   logic [3:0] m_nzcv, p_nzcv, m_flags;

   always #5 clk = ~clk;

   alu_pipe_flags dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .cntrl(cntrl), .set_flags(set_flags), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .negative(negative), .zero(zero), .overflow(overflow),
      .carry_out(carry_out), .flags(flags)
   );

   alu_pipe_flags #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8), .A(a8), .B(b8),
      .cntrl(op8), .set_flags(sf8), .out_valid(vld8), .out_ready(ordy8),
      .result(res8), .negative(n8), .zero(z8), .overflow(ov8),
      .carry_out(c8), .flags(flags8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op, output logic [3:0] nzcv);
      logic [64:0] s;
      logic [63:0] r;
      logic c, v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         3'd0: r = b;
         3'd1: r = a << b[5:0];
         3'd2: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[63:0];
            c = s[64];
            v = (a[63] == b[63]) && (r[63] != a[63]);
         end
         3'd3: begin
            r = a - b;
            c = a >= b;
            v = (a[63] != b[63]) && (r[63] != a[63]);
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = a * b;
      endcase
      nzcv = {r[63], r == 64'd0, c, v};
      return r;
   endfunction

   task automatic model_reset();
      m_vld = 1'b0; m_sf = 1'b0; m_busy = 0; m_res = '0; m_nzcv = '0; m_flags = '0;
      p_sf = 1'b0; p_res = '0; p_nzcv = '0;
   endtask

   task automatic drv(input logic v, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] op, input logic sf, input logic ordy);
      in_valid = v; A = a; B = b; cntrl = op; set_flags = sf; out_ready = ordy;
   endtask

   // check visible state against the model, then advance one clock edge
   task automatic cycle();
      logic rdy;
      logic [63:0] r;
      logic [3:0] f;
      #1;
      rdy = m_busy == 0 && (!m_vld || out_ready);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_vld);
      if (m_vld) begin
         chk("result", result, m_res);
         chk("nzcv", {negative, zero, carry_out, overflow}, m_nzcv);
      end
      chk("flags", flags, m_flags);
      if (reset) model_reset();
      else begin
         if (m_vld && out_ready) begin
            if (m_sf) m_flags = m_nzcv;
            m_vld = 1'b0;
         end
         if (in_valid && rdy) begin
            r = ref_op(A, B, cntrl, f);
            if (cntrl == 3'd7) begin
               m_busy = 64; p_res = r; p_nzcv = f; p_sf = set_flags;
            end else begin
               m_vld = 1'b1; m_res = r; m_nzcv = f; m_sf = set_flags;
            end
         end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_vld = 1'b1; m_res = p_res; m_nzcv = p_nzcv; m_sf = p_sf;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input logic exp_z);
      int n;
      drv(1'b1, a, b, 3'd7, 1'b0, 1'b1);
      cycle();
      n = 0;
      while (!out_valid && n < 200) begin
         drv(1'b1, 64'd5, 64'd9, 3'd2, 1'b1, 1'b1);
         cycle();
         n++;
      end
      chk("mul_latency", 64'(n), 64'd64);
      chk("mul_result", result, exp);
      chk("mul_zero", zero, 64'(exp_z));
      chk("mul_cv", {carry_out, overflow}, 64'd0);
      drv(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
      cycle();
   endtask

   task automatic rand_traffic(input int cycles);
      logic [63:0] a, b;
      for (int i = 0; i < cycles; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) a = '1;
         if ($urandom_range(0, 7) == 0) b = 64'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) b = a;
         drv($urandom_range(0, 3) != 0, a, b,
             $urandom_range(0, 15) == 0 ? 3'd7 : 3'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
         cycle();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_out_valid", out_valid, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_rflags", {negative, zero, carry_out, overflow}, 64'd0);
      chk("rst_flags", flags, 64'd0);
      chk("rst_in_ready", in_ready, 64'd1);
      reset = 1'b0;
      drv(1'b1, '1, 64'd1, 3'd2, 1'b1, 1'b1);
      cycle();
      chk("add_result", result, 64'd0);
      chk("add_nzcv", {negative, zero, carry_out, overflow}, 64'b0110);
      drv(1'b1, 64'd1, 64'h11, 3'd3, 1'b0, 1'b1);
      cycle();
      chk("add_flags", flags, 64'b0110);
      chk("sub_result", result, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("sub_nc", {negative, carry_out}, 64'b10);
      drv(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
      cycle();
      chk("sub_flags_hold", flags, 64'b0110);
      run_mul(64'd3, 64'd7, 64'd21, 1'b0);
      run_mul(64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);
      drv(1'b1, {16{4'hE}}, {16{4'h2}}, 3'd6, 1'b1, 1'b0);
      cycle();
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 64'd1, 64'd1, 3'd2, 1'b0, 1'b0);
         #1;
         chk("xor_stall_ready", in_ready, 64'd0);
         chk("xor_hold", result, {16{4'hC}});
         cycle();
      end
      drv(1'b1, 64'hF0F0, 64'h0FF0, 3'd4, 1'b0, 1'b1);
      cycle();
      chk("b2b_and", result, 64'h00F0);
      drv(1'b1, 64'hF0F0, 64'h0FF0, 3'd5, 1'b0, 1'b1);
      cycle();
      chk("b2b_or", result, 64'hFFF0);
      drv(1'b1, 64'd1, 64'd63, 3'd1, 1'b1, 1'b1);
      cycle();
      chk("b2b_lsl", result, 64'h8000_0000_0000_0000);
      chk("b2b_lsl_n", negative, 64'd1);
      rand_traffic(1500);
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      drv(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
      #1;
      chk("mid_rst_vld", out_valid, 64'd0);
      chk("mid_rst_result", result, 64'd0);
      chk("mid_rst_flags", flags, 64'd0);
      chk("mid_rst_ready", in_ready, 64'd1);
      rand_traffic(1500);
      drv(1'b0, '0, '0, 3'd0, 1'b0, 1'b1);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = 1'b1; op8 = 3'd4;
      @(posedge clk); #1;
      chk("w8_and", res8, 64'(a8 & b8));
      chk("w8_ready", rdy8, 64'd1);
      op8 = 3'd5;
      @(posedge clk); #1;
      chk("w8_or", res8, 64'(a8 | b8));
      op8 = 3'd1; a8 = 8'd1; b8 = 8'd7;
      @(posedge clk); #1;
      chk("w8_lsl", res8, 64'h80);
      chk("w8_nzcv", {n8, z8, c8, ov8}, 64'b1000);
      v8 = 1'b0;
      @(posedge clk); #1;
      chk("w8_drain", vld8, 64'd0);
      chk("w8_flags", flags8, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
